// File: rtl/sequence_counter.sv
// sequence_counter: 4-bit timing-state counter with one-hot T decode and wrap pulse
module sequence_counter #(
  parameter int CNT_W = 4,
  parameter int T_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CLR,
  input  logic             INR,
  output logic [T_W-1:0]   T,
  output logic [CNT_W-1:0] COUNT,
  output logic             WRAP
);
  logic [CNT_W-1:0] count = '0;
  logic wrap = 1'b0;
  // count register: reset, then clear over increment over hold; wrap flags a 15->0 increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap <= 1'b0;
    end else begin
      count <= CLR ? '0 : INR ? count + 1'b1 : count;
      wrap <= !CLR && INR && (&count);
    end
  end
  // one-hot timing decode straight from the registered count
  always_comb begin
    T = '0;
    T[count] = 1'b1;
  end
  assign COUNT = count;
  assign WRAP = wrap;
endmodule

// File: tb/tb_sequence_counter.sv
// tb_sequence_counter: table vectors, hand sequences and randomized model check for sequence_counter
module tb_sequence_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;
  logic inr = 1'b0;
  logic [15:0] t;
  logic [3:0] count;
  logic wrap;
  int total = 0;
  int bad = 0;
  int m_count = 0;
  int m_wrap = 0;

  typedef struct {
    logic r;
    logic c;
    logic i;
    int cnt;
    int wr;
  } vec_t;
  vec_t vecs[$];

  sequence_counter dut (
    .clk(clk), .rst_n(rst_n), .CLR(clr), .INR(inr),
    .T(t), .COUNT(count), .WRAP(wrap)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_all(string nm, int cnt, int wr);
    logic [31:0] onehot;
    onehot = 32'd1 << cnt;
    chk({nm, "_count"}, 32'(count), 32'(cnt));
    chk({nm, "_t"}, 32'(t), onehot);
    chk({nm, "_wrap"}, 32'(wrap), 32'(wr));
  endfunction

  task automatic apply(input logic r, input logic c, input logic i);
    rst_n = r;
    clr = c;
    inr = i;
    if (!r) begin
      m_count = 0;
      m_wrap = 0;
    end else if (c) begin
      m_count = 0;
      m_wrap = 0;
    end else if (i) begin
      m_wrap = (m_count == 15) ? 1 : 0;
      m_count = (m_count + 1) % 16;
    end else
      m_wrap = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_all("init", 0, 0);
    vecs.push_back('{1'b0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 0, 0});
    for (int k = 1; k <= 7; k++) vecs.push_back('{1'b1, 1'b0, 1'b1, k, 0});
    for (int k = 0; k < 4; k++) vecs.push_back('{1'b1, 1'b0, 1'b0, 7, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 9, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 0});
    for (int k = 1; k <= 15; k++) vecs.push_back('{1'b1, 1'b0, 1'b1, k, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 0});
    for (int k = 2; k <= 15; k++) vecs.push_back('{1'b1, 1'b0, 1'b1, k, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 0});
    foreach (vecs[n]) begin
      apply(vecs[n].r, vecs[n].c, vecs[n].i);
      chk_all($sformatf("vec%0d", n), vecs[n].cnt, vecs[n].wr);
    end
    apply(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) apply(1'b1, 1'b0, 1'b1);
    chk_all("at12", 12, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    inr = 1'b1;
    #2 inr = 1'b0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #1;
    chk_all("glitch_between", 12, 0);
    apply(1'b1, 1'b0, 1'b0);
    chk_all("glitch_after_edge", 12, 0);
    apply(1'b0, 1'b0, 1'b1);
    chk_all("midreset", 0, 0);
    for (int k = 0; k < 400; k++) begin
      apply($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      chk_all("rand", m_count, m_wrap);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sequence_counter.md
Name: sequence_counter

Overview:
- Timing-state generator for the basic-computer control unit.
- Holds a 4-bit sequence count and decodes it into a one-hot timing vector T (T0..T15).
- The controller sequences fetch/decode/execute phases from T, using INR to advance and CLR to restart at T0.

Parameters:
- CNT_W, 4, width of the internal sequence count register.
- T_W, 16, width of the one-hot timing output; must equal 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- CLR  input  1  synchronous clear: count <- 0 at the next edge.
- INR  input  1  synchronous increment: count <- count+1 at the next edge.
- T  output  T_W  one-hot decode of the count; T[k]=1 iff count==k.
- COUNT  output  CNT_W  current registered count value.
- WRAP  output  1  registered one-cycle pulse; 1 in the cycle after count wrapped from T_W-1 to 0 via INR.

Behaviour:
- One clock domain; single registered count; T is purely combinational from the registered count (no extra latency).
- Reset: rst_n low at a rising edge -> COUNT=0, T=16'h0001 (T0 asserted), WRAP=0 from the next cycle. Reset overrides CLR and INR.
- rst_n is synchronous: deasserting or asserting it between edges has no effect until the next rising edge.
- Priority per edge (rst_n high): CLR > INR > hold.
  - CLR=1 -> COUNT=0 regardless of INR; WRAP=0.
  - CLR=0, INR=1 -> COUNT=COUNT+1 modulo 2**CNT_W.
  - WRAP=1 only when COUNT was T_W-1; otherwise WRAP=0.
  - CLR=0, INR=0 -> COUNT holds; WRAP=0.
- Wrap-around: COUNT=15 with INR -> COUNT=0, T=16'h0001, WRAP=1 for exactly one cycle.
- T invariant: exactly one bit set at all times after the first reset edge; T[COUNT]=1, all other bits 0.
- Before the first reset edge, COUNT is initialised to 0 (simulation/FPGA init) so T=16'h0001 from time zero; CLR/INR of X are not required to be handled.
- CLR asserted while already at T0 -> stays at T0, no WRAP.
- INR held continuously -> T advances one position per clock: T0,T1,...,T15,T0,...
- Inputs are sampled only at the rising edge; glitches between edges are ignored.
- No handshake; the controller drives INR/CLR combinationally from T and the decoded opcode. The counter must tolerate both being high (CLR wins).

Test Plan:
- Reset: hold rst_n=0 two cycles with INR=1 -> COUNT=0, T=16'h0001, WRAP=0 each cycle; release rst_n with INR=1 -> next cycle T=16'h0002.
- Fetch sequence: from reset, INR=1 for 3 edges -> T goes 0x0001 -> 0x0002 -> 0x0004 -> 0x0008 (T3, execute phase), COUNT=3.
- Hold: at COUNT=5 drive INR=0, CLR=0 for 4 edges -> T stays 16'h0020, COUNT=5.
- Clear priority: at COUNT=9 drive CLR=1, INR=1 -> next cycle COUNT=0, T=16'h0001, WRAP=0.
- Wrap: INR=1 continuously for 16 edges from reset -> COUNT returns to 0, T=16'h0001, WRAP=1 for that single cycle only; 17th edge -> T=16'h0002, WRAP=0.
- Sync reset mid-count: at COUNT=12 pulse rst_n=0 between edges without a rising edge -> no change; held across an edge -> COUNT=0 next cycle.
